instruction_decode_unit: RTL and testbench

Front-end decode stage that sits directly upstream of the instruction schedule unit. It accepts raw 32-bit MIPS instruction words and their PCs from fetch through a valid/ready handshake and buffers them in a small FIFO. It decodes the FIFO head into register indices, immediate, jump target and single/double floating-point flags, then presents the result in a registered valid/ready output slot for register read.

---
 rtl/mpc_defines.sv | 38 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/instruction_decode_unit.sv | 194 +++++++++++++++++++
 tb/tb_instruction_decode_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_defines.sv
// Shared decode definitions: register/immediate/target widths, the
// opcode and COP1 format constants, and the illegal-opcode table that
// the optional DECODE_ILLEGAL_TRAP_EN build uses.
package mpc_defines;

    localparam int INTERNAL_REGISTER_WIDTH = 5;
    localparam int IMMEDIATE_WIDTH         = 16;
    localparam int TARGET_ADDR_WIDTH       = 26;
    localparam int OPCODE_WIDTH            = 6;
    localparam int FUNCT_WIDTH             = 6;
    localparam int FMT_WIDTH               = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_SPECIAL = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_COP1    = 6'h11;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW      = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW      = 6'h2B;

    localparam logic [FMT_WIDTH-1:0] FMT_S = 5'h10;
    localparam logic [FMT_WIDTH-1:0] FMT_D = 5'h11;

    // Opcodes the core does not implement; only consulted when the
    // illegal-instruction trap is built in.
    function automatic logic is_illegal_opcode(input logic [OPCODE_WIDTH-1:0] op);
        logic illegal;
        illegal = 1'b0;
        case (op)
            6'h12, 6'h13,
            6'h1C, 6'h1D, 6'h1E, 6'h1F,
            6'h32, 6'h33,
            6'h36, 6'h37, 6'h38,
            6'h3A, 6'h3B,
            6'h3E, 6'h3F: illegal = 1'b1;
            default:      illegal = 1'b0;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pointers wrap naturally;
// occupancy is kept in a separate counter one bit wider than the
// pointers so that full and empty are unambiguous. Flush empties it.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;

    // Next pointer/occupancy state; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instruction_decode_unit.sv
// Decode stage: buffers fetched {instruction, PC} pairs in a FIFO,
// decodes the head and hands it to the schedule unit through a
// registered valid/ready slot. Optional macro DECODE_ILLEGAL_TRAP_EN
// drops unimplemented opcodes and reports them on oIllegal/oIllegalPc.
module instruction_decode_unit
    import mpc_defines::*;
#(
    parameter int DEPTH         = 4,
    parameter int INSTR_WIDTH   = 32,
    parameter int REG_IDX_WIDTH = INTERNAL_REGISTER_WIDTH
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         iFlush,
    input  logic                         iInstrValid,
    input  logic [INSTR_WIDTH-1:0]       iInstr,
    input  logic [INSTR_WIDTH-1:0]       iPc,
    output logic                         oInstrReady,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [REG_IDX_WIDTH-1:0]     oRs,
    output logic [REG_IDX_WIDTH-1:0]     oRt,
    output logic [REG_IDX_WIDTH-1:0]     oRd,
    output logic [IMMEDIATE_WIDTH-1:0]   oImmediate,
    output logic [TARGET_ADDR_WIDTH-1:0] oTargetAddr,
    output logic [OPCODE_WIDTH-1:0]      oOpcode,
    output logic [FUNCT_WIDTH-1:0]       oFunct,
    output logic                         oSFPInstruction,
    output logic                         oDFPInstruction,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                         oIllegal,
    output logic [INSTR_WIDTH-1:0]       oIllegalPc,
`endif
    output logic [INSTR_WIDTH-1:0]       oPc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]         fifo_count, count_next;
    logic [2*INSTR_WIDTH-1:0] head_data;
    logic [INSTR_WIDTH-1:0]   head_instr, head_pc;
    logic                     head_illegal, slot_load;

    logic                         in_ready_q, in_ready_d;
    logic                         valid_q, valid_d;
    logic [REG_IDX_WIDTH-1:0]     rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [IMMEDIATE_WIDTH-1:0]   imm_q, imm_d;
    logic [TARGET_ADDR_WIDTH-1:0] target_q, target_d;
    logic [OPCODE_WIDTH-1:0]      opcode_q, opcode_d;
    logic [FUNCT_WIDTH-1:0]       funct_q, funct_d;
    logic                         sfp_q, sfp_d, dfp_q, dfp_d;
    logic [INSTR_WIDTH-1:0]       pc_q, pc_d;
    logic                         illegal_q, illegal_d;
    logic [INSTR_WIDTH-1:0]       illegal_pc_q, illegal_pc_d;

    logic [REG_IDX_WIDTH-1:0]     dec_rs, dec_rt, dec_rd;
    logic                         dec_sfp, dec_dfp;

    assign head_instr = head_data[2*INSTR_WIDTH-1:INSTR_WIDTH];
    assign head_pc    = head_data[INSTR_WIDTH-1:0];

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign head_illegal = is_illegal_opcode(head_instr[31:26]);
`else
    assign head_illegal = 1'b0;
`endif

    // An illegal head is discarded without waiting for the output slot.
    assign fifo_push = iInstrValid && in_ready_q && !fifo_full && !iFlush;
    assign fifo_pop  = !fifo_empty && !iFlush && (head_illegal || !valid_q || iReady);
    assign slot_load = fifo_pop && !head_illegal;

    sync_fifo #(
        .WIDTH (2*INSTR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data ({iInstr, iPc}),
        .pop       (fifo_pop),
        .flush     (iFlush),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Field decode of the FIFO head; COP1 moves fs/ft/fd into rs/rt/rd.
    always_comb begin
        dec_rs  = REG_IDX_WIDTH'(head_instr[25:21]);
        dec_rt  = REG_IDX_WIDTH'(head_instr[20:16]);
        dec_rd  = REG_IDX_WIDTH'(head_instr[15:11]);
        dec_sfp = 1'b0;
        dec_dfp = 1'b0;
        if (head_instr[31:26] == OP_COP1) begin
            dec_rs  = REG_IDX_WIDTH'(head_instr[15:11]);
            dec_rt  = REG_IDX_WIDTH'(head_instr[20:16]);
            dec_rd  = REG_IDX_WIDTH'(head_instr[10:6]);
            dec_sfp = (head_instr[25:21] == FMT_S);
            dec_dfp = (head_instr[25:21] == FMT_D);
        end
    end

    // Next state of the output slot, input-ready flag and illegal report.
    always_comb begin
        count_next   = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        in_ready_d   = iFlush ? 1'b1 : (count_next < CNT_W'(DEPTH));
        valid_d      = valid_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        imm_d        = imm_q;
        target_d     = target_q;
        opcode_d     = opcode_q;
        funct_d      = funct_q;
        sfp_d        = sfp_q;
        dfp_d        = dfp_q;
        pc_d         = pc_q;
        illegal_d    = fifo_pop && head_illegal;
        illegal_pc_d = illegal_d ? head_pc : illegal_pc_q;
        if (iFlush) begin
            valid_d = 1'b0;
        end else if (slot_load) begin
            valid_d  = 1'b1;
            rs_d     = dec_rs;
            rt_d     = dec_rt;
            rd_d     = dec_rd;
            imm_d    = head_instr[15:0];
            target_d = head_instr[25:0];
            opcode_d = head_instr[31:26];
            funct_d  = head_instr[5:0];
            sfp_d    = dec_sfp;
            dfp_d    = dec_dfp;
            pc_d     = head_pc;
        end else if (iReady) begin
            valid_d = 1'b0;
        end
    end

    // Output slot registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_ready_q   <= 1'b0;
            valid_q      <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            target_q     <= '0;
            opcode_q     <= '0;
            funct_q      <= '0;
            sfp_q        <= 1'b0;
            dfp_q        <= 1'b0;
            pc_q         <= '0;
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            valid_q      <= valid_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            target_q     <= target_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            sfp_q        <= sfp_d;
            dfp_q        <= dfp_d;
            pc_q         <= pc_d;
            illegal_q    <= illegal_d;
            illegal_pc_q <= illegal_pc_d;
        end
    end

    assign oInstrReady     = in_ready_q;
    assign oValid          = valid_q;
    assign oRs             = rs_q;
    assign oRt             = rt_q;
    assign oRd             = rd_q;
    assign oImmediate      = imm_q;
    assign oTargetAddr     = target_q;
    assign oOpcode         = opcode_q;
    assign oFunct          = funct_q;
    assign oSFPInstruction = sfp_q;
    assign oDFPInstruction = dfp_q;
    assign oPc             = pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign oIllegal        = illegal_q;
    assign oIllegalPc      = illegal_pc_q;
`endif

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Testbench for instruction_decode_unit: directed test-plan steps,
// randomized traffic with flushes and an asynchronous reset, checked
// against a queue-based reference model. Honours DECODE_ILLEGAL_TRAP_EN.
module tb_instruction_decode_unit;

    localparam int DEPTH = 4;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        iFlush = 1'b0;
    logic        iInstrValid = 1'b0;
    logic        iReady = 1'b0;
    logic [31:0] iInstr = '0;
    logic [31:0] iPc = '0;
    logic        oInstrReady, oValid, oSFPInstruction, oDFPInstruction;
    logic [4:0]  oRs, oRt, oRd;
    logic [15:0] oImmediate;
    logic [25:0] oTargetAddr;
    logic [5:0]  oOpcode, oFunct;
    logic [31:0] oPc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        oIllegal;
    logic [31:0] oIllegalPc;
`endif

    always #5 clk = ~clk;

    instruction_decode_unit #(.DEPTH(DEPTH), .INSTR_WIDTH(32), .REG_IDX_WIDTH(5)) dut (
        .clk(clk), .resetn(resetn), .iFlush(iFlush),
        .iInstrValid(iInstrValid), .iInstr(iInstr), .iPc(iPc),
        .oInstrReady(oInstrReady), .oValid(oValid), .iReady(iReady),
        .oRs(oRs), .oRt(oRt), .oRd(oRd), .oImmediate(oImmediate),
        .oTargetAddr(oTargetAddr), .oOpcode(oOpcode), .oFunct(oFunct),
        .oSFPInstruction(oSFPInstruction), .oDFPInstruction(oDFPInstruction),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .oIllegal(oIllegal), .oIllegalPc(oIllegalPc),
`endif
        .oPc(oPc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      fq[$];
    bit          m_valid, m_ready, m_ill;
    entry_t      m_slot;
    logic [31:0] m_ill_pc;
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference decode, straight from the field definitions.
    function automatic void exp_decode(input logic [31:0] w, output logic [4:0] rs,
                                       output logic [4:0] rt, output logic [4:0] rd,
                                       output logic sfp, output logic dfp);
        int op, fmt;
        op  = int'(w >> 26);
        fmt = int'((w >> 21) & 32'h1f);
        if (op == 17) begin
            rs  = 5'((w >> 11) & 32'h1f);
            rt  = 5'((w >> 16) & 32'h1f);
            rd  = 5'((w >> 6) & 32'h1f);
            sfp = (fmt == 16);
            dfp = (fmt == 17);
        end else begin
            rs  = 5'((w >> 21) & 32'h1f);
            rt  = 5'((w >> 16) & 32'h1f);
            rd  = 5'((w >> 11) & 32'h1f);
            sfp = 1'b0;
            dfp = 1'b0;
        end
    endfunction

    function automatic bit is_illegal(input logic [31:0] w);
        int op;
        op = int'(w >> 26);
        return ILL_EN && ((op == 'h12) || (op == 'h13) || (op >= 'h1C && op <= 'h1F) ||
                          (op == 'h32) || (op == 'h33) || (op >= 'h36 && op <= 'h38) ||
                          (op == 'h3A) || (op == 'h3B) || (op >= 'h3E));
    endfunction

    task automatic model_reset();
        fq.delete();
        m_valid  = 1'b0;
        m_ready  = 1'b0;
        m_ill    = 1'b0;
        m_ill_pc = '0;
        m_slot   = '{instr: '0, pc: '0};
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit     do_push, do_pop, ill;
        entry_t head;
        if (!resetn) begin
            model_reset();
            return;
        end
        m_ill = 1'b0;
        if (iFlush) begin
            fq.delete();
            m_valid = 1'b0;
            m_ready = 1'b1;
            return;
        end
        do_push = iInstrValid && m_ready;
        do_pop  = 1'b0;
        ill     = 1'b0;
        head    = '{instr: '0, pc: '0};
        if (fq.size() > 0) begin
            head   = fq[0];
            ill    = is_illegal(head.instr);
            do_pop = ill || !m_valid || iReady;
        end
        if (do_pop) void'(fq.pop_front());
        if (do_pop && ill) begin
            m_ill    = 1'b1;
            m_ill_pc = head.pc;
        end
        if (do_pop && !ill) begin
            m_slot  = head;
            m_valid = 1'b1;
        end else if (iReady) begin
            m_valid = 1'b0;
        end
        if (do_push) fq.push_back('{instr: iInstr, pc: iPc});
        m_ready = (fq.size() < DEPTH);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_output(input string tag);
        logic [4:0] rs, rt, rd;
        logic       sfp, dfp;
        chk({tag, ".valid"}, 64'(oValid), 64'(m_valid));
        chk({tag, ".ready"}, 64'(oInstrReady), 64'(m_ready));
        if (m_valid) begin
            exp_decode(m_slot.instr, rs, rt, rd, sfp, dfp);
            chk({tag, ".rs"}, 64'(oRs), 64'(rs));
            chk({tag, ".rt"}, 64'(oRt), 64'(rt));
            chk({tag, ".rd"}, 64'(oRd), 64'(rd));
            chk({tag, ".sfp"}, 64'(oSFPInstruction), 64'(sfp));
            chk({tag, ".dfp"}, 64'(oDFPInstruction), 64'(dfp));
            chk({tag, ".imm"}, 64'(oImmediate), 64'(m_slot.instr & 32'hffff));
            chk({tag, ".target"}, 64'(oTargetAddr), 64'(m_slot.instr % (32'd1 << 26)));
            chk({tag, ".opcode"}, 64'(oOpcode), 64'(m_slot.instr >> 26));
            chk({tag, ".funct"}, 64'(oFunct), 64'(m_slot.instr & 32'h3f));
            chk({tag, ".pc"}, 64'(oPc), 64'(m_slot.pc));
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk({tag, ".illegal"}, 64'(oIllegal), 64'(m_ill));
        if (m_ill) chk({tag, ".illegal_pc"}, 64'(oIllegalPc), 64'(m_ill_pc));
`endif
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".valid"}, 64'(oValid), 64'd0);
        chk({tag, ".ready"}, 64'(oInstrReady), 64'd0);
        chk({tag, ".fields"}, {oRs, oRt, oRd, oImmediate, oOpcode, oFunct,
                               oSFPInstruction, oDFPInstruction}, 64'd0);
        chk({tag, ".target"}, 64'(oTargetAddr), 64'd0);
        chk({tag, ".pc"}, 64'(oPc), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk({tag, ".illegal"}, 64'(oIllegal), 64'd0);
        chk({tag, ".illegal_pc"}, 64'(oIllegalPc), 64'd0);
`endif
    endtask

    // Offer one instruction until accepted (bounded), checking each cycle.
    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc, input string tag);
        bit acc;
        acc         = 1'b0;
        iInstrValid = 1'b1;
        iInstr      = instr;
        iPc         = pc;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = m_ready;
            apply_stimulus();
            check_output(tag);
        end
        chk({tag, ".accepted"}, 64'(acc), 64'd1);
        iInstrValid = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: begin
                w[31:26] = 6'h11;
                case ($urandom_range(0, 2))
                    0: w[25:21] = 5'h10;
                    1: w[25:21] = 5'h11;
                    default: w[25:21] = 5'($urandom);
                endcase
            end
            1: w[31:26] = 6'h00;
            2: w[31:26] = 6'h23;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        #1 resetn = 1'b0;
        repeat (3) apply_stimulus();
        check_reset("reset");
        resetn = 1'b1;
        apply_stimulus();
        check_output("idle");
        chk("idle.ready_up", 64'(oInstrReady), 64'd1);

        // Directed decodes with the consumer always ready.
        iReady = 1'b1;
        push_one(32'h00221820, 32'h100, "add_push");
        apply_stimulus();
        check_output("add");
        chk("add.dir", {oValid, oRs, oRt, oRd, oSFPInstruction, oDFPInstruction},
            {1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0});
        chk("add.dir_pc", 64'(oPc), 64'h100);
        push_one(32'h46020040, 32'h104, "adds_push");
        apply_stimulus();
        check_output("adds");
        chk("adds.dir", {oRs, oRt, oRd, oSFPInstruction, oDFPInstruction},
            {5'd0, 5'd2, 5'd1, 1'b1, 1'b0});
        push_one(32'h46220040, 32'h108, "addd_push");
        apply_stimulus();
        check_output("addd");
        chk("addd.dir", {oSFPInstruction, oDFPInstruction}, {1'b0, 1'b1});
        push_one(32'h8C410004, 32'h10C, "lw_push");
        apply_stimulus();
        check_output("lw");
        chk("lw.dir", {oRs, oRt, oImmediate, oOpcode}, {5'd2, 5'd1, 16'h0004, 6'h23});
        apply_stimulus();
        check_output("drain");

        // Backpressure: five instructions, ready must drop, then in-order drain.
        iReady = 1'b0;
        for (int i = 0; i < 5; i++) push_one(gen_instr(), 32'h300 + 32'(i * 4), "bp_push");
        chk("bp.ready_low", 64'(oInstrReady), 64'd0);
        iReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.order_valid", 64'(oValid), 64'd1);
            chk("bp.order_pc", 64'(oPc), 64'h300 + 64'(i * 4));
            apply_stimulus();
            check_output("bp_drain");
        end
        chk("bp.empty", 64'(oValid), 64'd0);

        // Flush with a push offered in the same cycle.
        iReady = 1'b0;
        for (int i = 0; i < 4; i++) push_one(gen_instr(), 32'h400 + 32'(i * 4), "fl_push");
        iFlush      = 1'b1;
        iInstrValid = 1'b1;
        iInstr      = 32'h00221820;
        iPc         = 32'h4F0;
        apply_stimulus();
        iFlush      = 1'b0;
        iInstrValid = 1'b0;
        check_output("flush");
        chk("flush.valid", 64'(oValid), 64'd0);
        chk("flush.ready", 64'(oInstrReady), 64'd1);
        iReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("post_flush");
            chk("post_flush.valid", 64'(oValid), 64'd0);
        end

`ifdef DECODE_ILLEGAL_TRAP_EN
        begin
            int pulses, delivered;
            pulses    = 0;
            delivered = 0;
            push_one(32'hFC000000, 32'h200, "ill_push");
            push_one(32'h00221820, 32'h204, "ill_legal_push");
            if (oIllegal) pulses++;
            for (int i = 0; i < 6; i++) begin
                if (oValid) begin
                    delivered++;
                    chk("ill.legal_pc", 64'(oPc), 64'h204);
                end
                if (oIllegal) chk("ill.pc", 64'(oIllegalPc), 64'h200);
                apply_stimulus();
                check_output("ill");
                if (oIllegal) pulses++;
            end
            chk("ill.pulses", 64'(pulses), 64'd1);
            chk("ill.delivered", 64'(delivered), 64'd1);
        end
`endif

        // Randomized traffic with occasional flushes and one async reset.
        for (int i = 0; i < 400; i++) begin
            iInstrValid = ($urandom_range(0, 3) != 0);
            iReady      = ($urandom_range(0, 3) != 0);
            iFlush      = ($urandom_range(0, 31) == 0);
            iInstr      = gen_instr();
            iPc         = $urandom & 32'hFFFF_FFFC;
            if (i == 200) begin
                #3 resetn = 1'b0;
                #1;
                model_reset();
                check_reset("async_reset");
                apply_stimulus();
                check_reset("async_reset_hold");
                resetn = 1'b1;
            end
            apply_stimulus();
            check_output("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
